seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 172 +++++++++++++++++
 tb/tb_seq_alu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/shift/add ops, WIDTH-cycle iterative
// multiply and restoring unsigned divide, valid/ready on both sides.
//
// state | meaning
// IDLE  | ready_o high, waiting for valid_i
// BUSY  | iterating MUL/DIVU/REMU, one step per cycle
// DONE  | valid_o high, holding result until ready_i
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_DIVU = 4'hB;
    localparam logic [3:0] OP_REMU = 4'hC;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // MUL partial product / DIV remainder
    logic [WIDTH-1:0] mq_q, mq_d;     // MUL multiplier / DIV dividend->quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // MUL shifted multiplicand / DIV divisor
    logic             eq_q, eq_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] simple_res;
    logic             slt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] quo_new;
    logic [WIDTH-1:0] prod_new;
    logic             is_long;

    assign shamt   = data2_i[SHW-1:0];
    assign slt     = $signed(data1_i) < $signed(data2_i);
    assign is_long = (ALUCtrl_i == OP_MUL) || (ALUCtrl_i == OP_DIVU) ||
                     (ALUCtrl_i == OP_REMU);

    always_comb begin
        simple_res = data1_i;
        case (ALUCtrl_i)
            4'h0:       simple_res = data1_i & data2_i;
            4'h1:       simple_res = data1_i ^ data2_i;
            4'h2:       simple_res = data1_i << shamt;
            4'h3, 4'h6: simple_res = data1_i + data2_i;
            4'h4:       simple_res = data1_i - data2_i;
            4'h7:       simple_res = $signed(data1_i) >>> shamt;
            4'h8:       simple_res = data1_i | data2_i;
            4'h9:       simple_res = data1_i >> shamt;
            4'hA:       simple_res = {{(WIDTH-1){1'b0}}, slt};
            default:    simple_res = data1_i;
        endcase
    end

    // Restoring divide step; a zero divisor naturally yields all-ones/A.
    always_comb begin
        rem_sh   = {acc_q, mq_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        if (!rem_diff[WIDTH]) begin
            rem_new = rem_diff[WIDTH-1:0];
            quo_new = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_new = rem_sh[WIDTH-1:0];
            quo_new = {mq_q[WIDTH-2:0], 1'b0};
        end
        prod_new = mq_q[0] ? (acc_q + opb_q) : acc_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opb_d   = opb_q;
        eq_d    = eq_q;
        data_d  = data_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op_d = ALUCtrl_i;
                    eq_d = (data1_i == data2_i);
                    if (is_long) begin
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                        mq_d    = (ALUCtrl_i == OP_MUL) ? data2_i : data1_i;
                        opb_d   = (ALUCtrl_i == OP_MUL) ? data1_i : data2_i;
                        state_d = BUSY;
                    end else begin
                        data_d  = simple_res;
                        zero_d  = (data1_i == data2_i);
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = prod_new;
                    mq_d  = mq_q >> 1;
                    opb_d = opb_q << 1;
                end else begin
                    acc_d = rem_new;
                    mq_d  = quo_new;
                end
                if (cnt_q == CW'(1)) begin
                    case (op_q)
                        OP_MUL:  data_d = prod_new;
                        OP_DIVU: data_d = quo_new;
                        default: data_d = rem_new;
                    endcase
                    zero_d  = eq_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opb_q   <= '0;
            eq_q    <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opb_q   <= opb_d;
            eq_q    <= eq_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign data_o  = data_q;
    assign Zero_o  = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): hand-computed results, latency,
// back-pressure hold and mid-operation reset.
module tb_seq_alu;

    logic        clk_sys = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [3:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic        Zero_o;

    int n_chk  = 0;
    int n_pass = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk_i     (clk_sys),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .Zero_o    (Zero_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one op, measure edges from accept to valid_o, check result, release.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d,
                          input logic exp_z, input int exp_lat);
        int lat;
        @(negedge clk_sys);
        chk({tag, " ready_o"}, 32'(ready_o), 32'd1);
        valid_i   = 1'b1;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        @(posedge clk_sys);
        #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk_sys);
            #1;
            lat++;
        end
        chk({tag, " valid_o"}, 32'(valid_o), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " data_o"}, data_o, exp_d);
        chk({tag, " Zero_o"}, 32'(Zero_o), 32'(exp_z));
        ready_i = 1'b1;
        @(posedge clk_sys);
        #1;
        ready_i = 1'b0;
        chk({tag, " ready_o after"}, 32'(ready_o), 32'd1);
        chk({tag, " valid_o after"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        ALUCtrl_i = 4'h0;
        data1_i   = '0;
        data2_i   = '0;
        ready_i   = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst ready_o", 32'(ready_o), 32'd1);
        chk("rst valid_o", 32'(valid_o), 32'd0);
        chk("rst data_o", data_o, 32'd0);
        chk("rst Zero_o", 32'(Zero_o), 32'd0);
        rst_i = 1'b0;

        run_op("ADD",   4'h3, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1);
        run_op("SRA",   4'h7, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1);
        run_op("SLT",   4'hA, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1);
        run_op("AND",   4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1);
        run_op("XOR",   4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1);
        run_op("SLL",   4'h2, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1);
        run_op("SUB",   4'h4, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1);
        run_op("ADDI",  4'h6, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1);
        run_op("OR",    4'h8, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0, 1);
        run_op("SRL",   4'h9, 32'h80000000, 32'h0000003F, 32'h00000001, 1'b0, 1);
        run_op("PASS",  4'hD, 32'h00001234, 32'h00001234, 32'h00001234, 1'b1, 1);
        run_op("MUL",   4'h5, 32'h00010001, 32'h00010001, 32'h00020001, 1'b1, 33);
        run_op("MULff", 4'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 33);
        run_op("DIVU",  4'hB, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        run_op("REMU",  4'hC, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        run_op("DIV0",  4'hB, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 33);
        run_op("REM0",  4'hC, 32'd5,        32'd0,        32'd5,        1'b0, 33);
        run_op("DIV00", 4'hB, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 33);
        run_op("REM00", 4'hC, 32'd0,        32'd0,        32'd0,        1'b1, 33);
        run_op("DIVmx", 4'hB, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33);
        run_op("REM10", 4'hC, 32'hFFFFFFFF, 32'd10,       32'd5,        1'b0, 33);

        // Back-pressure: hold DONE with ready_i low while valid_i pulses.
        @(negedge clk_sys);
        valid_i = 1'b1; ALUCtrl_i = 4'h3; data1_i = 32'd1; data2_i = 32'd1;
        @(posedge clk_sys);
        #1;
        for (int i = 0; i < 10; i++) begin
            valid_i   = i[0];
            ALUCtrl_i = 4'h4;
            data1_i   = 32'd9;
            data2_i   = 32'd3;
            @(negedge clk_sys);
            chk("hold valid_o", 32'(valid_o), 32'd1);
            chk("hold data_o", data_o, 32'd2);
            chk("hold Zero_o", 32'(Zero_o), 32'd1);
            chk("hold ready_o", 32'(ready_o), 32'd0);
            @(posedge clk_sys);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_sys);
        #1;
        ready_i = 1'b0;
        chk("hold release ready_o", 32'(ready_o), 32'd1);
        chk("hold release valid_o", 32'(valid_o), 32'd0);

        // Reset at cycle 10 of a multiply aborts it.
        @(negedge clk_sys);
        valid_i = 1'b1; ALUCtrl_i = 4'h5; data1_i = 32'd3; data2_i = 32'd5;
        @(posedge clk_sys);
        #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("mid-mul ready_o", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_sys);
        #1;
        rst_i = 1'b0;
        chk("abort valid_o", 32'(valid_o), 32'd0);
        chk("abort ready_o", 32'(ready_o), 32'd1);
        chk("abort data_o", data_o, 32'd0);
        chk("abort Zero_o", 32'(Zero_o), 32'd0);
        repeat (40) begin
            @(negedge clk_sys);
            if (valid_o) chk("abort stray valid_o", 32'(valid_o), 32'd0);
        end
        run_op("ADD post-rst", 4'h3, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
